// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_pkg;

    // Bit-counter phase: IDLE waits for the first bit of a word, SHIFT is mid-word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned WCNT_W    = 8;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts accepted serial bits within a word and flags the final bit position.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     last
);

    localparam int unsigned       CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_d;

    assign last = (cnt == CNT_LAST);

    // State and bit-position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
        end
    end

    // Next-state: clear wins, otherwise advance on each accepted bit and wrap after the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (inc) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with a one-word valid/ready output slot and overrun flag.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [WIDTH-1:0]  q_data,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              overrun,
    output logic [WCNT_W-1:0] word_cnt
);

    logic [WIDTH-1:0]         acc;
    logic [WIDTH-1:0]         acc_next;
    logic [$clog2(WIDTH)-1:0] cnt_unused;   // completion only needs 'last'
    logic                     last;
    logic                     accept;
    logic                     complete;
    logic                     drain;

    assign accept   = sin_valid && !clr;
    assign complete = accept && last;
    assign drain    = q_valid && q_ready;

    // Accumulator with the current bit shifted in; on completion this is the finished word.
    generate
        if (MSB_FIRST) begin : g_msb
            assign acc_next = {acc[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign acc_next = {sin, acc[WIDTH-1:1]};
        end
    endgenerate

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (accept),
        .cnt  (cnt_unused),
        .last (last)
    );

    // Shift register for the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
        end
    end

    // Output slot: load when empty or draining this edge, else just drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data   <= '0;
            q_valid  <= 1'b0;
            word_cnt <= '0;
        end else if (complete && (!q_valid || q_ready)) begin
            q_data   <= acc_next;
            q_valid  <= 1'b1;
            word_cnt <= word_cnt + 1'b1;
        end else if (drain) begin
            q_valid  <= 1'b0;
        end
    end

    // Sticky overrun: set when a finished word finds the slot full and not draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (clr) begin
            overrun <= 1'b0;
        end else if (complete && q_valid && !q_ready) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer that assembles a one-bit serial stream into WIDTH-bit words and presents them on a registered valid/ready output. It is the stage directly upstream of the 4-bit parallel-in/parallel-out register and drives that register's d input. It adds a bit counter, frame completion, one-word output buffering and overrun detection.

## Interface
- WIDTH, 4: word width in bits; legal range 2..16.
- MSB_FIRST, 1: 1 = first received bit lands in q_data[WIDTH-1]; 0 = first bit lands in q_data[0].

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of the partial word and of overrun.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on this edge; there is no backpressure on the serial side.
- q_data  out  WIDTH  completed word; registered.
- q_valid  out  1  q_data holds an unconsumed word.
- q_ready  in  1  consumer accepts; a transfer occurs on an edge with q_valid && q_ready.
- overrun  out  1  sticky; a completed word was dropped.
- word_cnt  out  8  count of words loaded into q_data; wraps 255 -> 0.

## Operation
- Accumulator acc[WIDTH-1:0] and bit counter cnt (0..WIDTH-1).
- States:
  - IDLE (cnt==0).
  - SHIFT (0<cnt<WIDTH).
- Accept condition: sin_valid && !clr.
- On accept:
  - MSB_FIRST=1: acc <= {acc[WIDTH-2:0], sin}.
  - MSB_FIRST=0: acc <= {sin, acc[WIDTH-1:1]}.
  - cnt increments.
- Completion: accept while cnt==WIDTH-1.
  - cnt returns to 0 (IDLE).
  - The formed word (acc shifted with the current sin) is the completion word.
- Output slot logic on a completion:
  - If !q_valid, or q_valid && q_ready on the same edge: q_data <= word, q_valid <= 1, word_cnt increments.
  - Otherwise the word is dropped, overrun <= 1, and q_data is unchanged.
- No completion and q_valid && q_ready: q_valid <= 0; q_data keeps its last value.
- clr:
  - Sets acc, cnt and overrun to 0. A sin_valid bit on the same edge is discarded.
  - Does not affect q_data, q_valid or word_cnt.
- Sampling: sin is ignored when sin_valid=0. Gaps between bits are allowed, and the partial word is held indefinitely.

## Timing
- Reset values: q_data=0, q_valid=0, overrun=0, word_cnt=0, acc=0, cnt=0 (IDLE).
- Reset acts immediately. A partial word in progress is lost. No output toggles after deassertion until new bits are accepted.
- Latency: q_valid and q_data update on the same edge that samples the WIDTH-th bit. At one bit per cycle, q_valid is high in the cycle after the last bit is presented.
- Throughput: one word per WIDTH cycles. With q_ready tied high, overrun never sets.
- Simultaneous completion and drain on one edge: the new word replaces the old one and q_valid stays 1 (no bubble).
- Overrun:
  - Set on the dropping edge.
  - Cleared only by clr or rst.
  - Further drops while it is set change nothing else.
- word_cnt: 8-bit modulo; it increments only on a load, not on a drop.

## Structure
- Package sipo_pkg holds:
  - the state enum {IDLE, SHIFT};
  - the default WIDTH constant (4);
  - the word_cnt width constant (8).
- One sub-module, sipo_bit_counter:
  - parameter WIDTH; inputs clk, rst, clr, inc.
  - Outputs cnt and last (cnt==WIDTH-1).
  - last is used for completion detection.
- The top level holds the accumulator, the output slot and the overrun and word_cnt registers.

## Test plan
- Reset, basic word:
  - Stimulus: assert rst mid-stream, then release. Feed 0,0,1,1 with MSB_FIRST=1, one bit per cycle, q_ready=1.
  - Response: q_data=4'b0011 and q_valid=1 on the 4th sampling edge; word_cnt=1.
- Back-to-back words, no bubble:
  - Stimulus: stream 1100, 1010, 1111 continuously with q_ready=1.
  - Response: q_data sequence 4'b1100, 4'b1010, 4'b1111, each valid one cycle; overrun=0; word_cnt=3.
- LSB-first and gaps:
  - Stimulus: MSB_FIRST=0; feed 1,0,0,0 with sin_valid low for 3 cycles between bits.
  - Response: q_data=4'b0001, loaded only on the 4th valid bit.
- Overrun:
  - Stimulus: q_ready=0; send 0011 then 0101.
  - Response: q_data stays 4'b0011, q_valid=1, overrun=1, word_cnt=1. Then q_ready=1 for one cycle: q_valid drops to 0.
- clr mid-word:
  - Stimulus: send 1,1; then clr together with sin_valid=1; then send 0,1,1,0.
  - Response: q_data=4'b0110 and overrun=0.
- Reset mid-word:
  - Stimulus: send 1,0,1, assert rst asynchronously, release, then send 1,0,0,1.
  - Response: outputs are 0 during reset; q_data=4'b1001 afterwards.
